// File: rtl/psum_align_pkg.sv
// Shared defaults and width helpers for the psum column-deskew buffer.
package psum_align_pkg;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 64;

  function automatic int addr_w(input int d);
    return $clog2(d);
  endfunction

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/psum_align_fifo_col_fifo.sv
// Single-lane synchronous FIFO; dout is the combinational head entry.
// push/pop arrive already qualified by the parent, so no full/empty guarding here.
module col_fifo
  import psum_align_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [width-1:0]          din,
  output logic [width-1:0]          dout,
  output logic [cnt_w(depth)-1:0]   cnt
);
  localparam int AW = addr_w(depth);
  localparam int CW = cnt_w(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign dout = mem[rptr];

  // Storage is intentionally left uninitialised; only pointers and count reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/psum_align_fifo.sv
// Column-deskew buffer: per-column FIFOs, a full row is released only when
// every column holds an entry; the row is registered onto out with a 1-cycle valid.
module psum_align_fifo
  import psum_align_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);
  localparam int CW = cnt_w(depth);

  logic [CW-1:0]          cnt [col];
  logic [col-1:0]         nonempty;
  logic [col-1:0]         full;
  logic [col-1:0]         push;
  logic [col-1:0]         drop;
  logic [psum_bw*col-1:0] head;
  logic                   pop;

  for (genvar k = 0; k < col; k++) begin : g_col
    col_fifo #(.width(psum_bw), .depth(depth)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[k]),
      .pop   (pop),
      .din   (in[psum_bw*k +: psum_bw]),
      .dout  (head[psum_bw*k +: psum_bw]),
      .cnt   (cnt[k])
    );

    assign nonempty[k] = (cnt[k] != '0);
    assign full[k]     = (cnt[k] == CW'(depth));
    // A same-cycle pop frees the slot, so a full column can still accept a write.
    assign push[k]     = wr[k] & (~full[k] | pop);
    assign drop[k]     = wr[k] & full[k] & ~pop;
  end

  assign o_valid = &nonempty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop)   out      <= head;
      if (|drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_psum_align_fifo.sv
// Directed bench for psum_align_fifo (col=8, psum_bw=16, depth=4).
module tb_psum_align_fifo;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   wr;
  logic [127:0] in;
  logic         rd;
  logic [127:0] out;
  logic         out_valid, o_valid, o_full, o_ready, overflow;

  int vecs = 0;
  int errs = 0;

  psum_align_fifo #(.col(8), .psum_bw(16), .depth(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (in),
    .rd        (rd),
    .out       (out),
    .out_valid (out_valid),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Inputs change 1 time unit after the edge; outputs are sampled then too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    step(); step();
    reset = 1'b0;
    vecs++; if (out !== 128'h0) begin errs++; $display("FAIL rst_out: got %h want 0", out); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
    vecs++; if (o_full !== 1'b0) begin errs++; $display("FAIL rst_o_full: got %b want 0", o_full); end
    vecs++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rst_o_ready: got %b want 1", o_ready); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_staggered_fill();
    logic [127:0] exp_row;
    exp_row = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    for (int k = 0; k < 8; k++) begin
      wr = 8'(1 << k);
      in = '0;
      in[16*k +: 16] = 16'h0100 + 16'(k);
      step();
      vecs++;
      if (o_valid !== (k == 7)) begin
        errs++; $display("FAIL stag_o_valid k=%0d: got %b want %b", k, o_valid, (k == 7));
      end
    end
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    vecs++; if (out !== exp_row) begin errs++; $display("FAIL stag_out: got %h want %h", out, exp_row); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stag_out_valid: got %b want 1", out_valid); end
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL stag_drain_o_valid: got %b want 0", o_valid); end
    step();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stag_pulse_end: got %b want 0", out_valid); end
    vecs++; if (out !== exp_row) begin errs++; $display("FAIL stag_out_hold: got %h want %h", out, exp_row); end
  endtask

  task automatic test_idle_read();
    logic [127:0] held;
    logic [127:0] exp_row;
    held = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    rd = 1'b1; wr = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL idle_out_valid i=%0d: got %b want 0", i, out_valid); end
      vecs++; if (out !== held) begin errs++; $display("FAIL idle_out i=%0d: got %h want %h", i, out, held); end
      vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL idle_o_valid i=%0d: got %b want 0", i, o_valid); end
    end
    // One row in, one row out: proves the counts really stayed at zero.
    rd = 1'b0; wr = 8'hFF;
    for (int k = 0; k < 8; k++) in[16*k +: 16] = 16'h0200 + 16'(k);
    exp_row = in;
    step();
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    vecs++; if (out !== exp_row) begin errs++; $display("FAIL idle_after_out: got %h want %h", out, exp_row); end
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL idle_after_o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr = 8'h08; in = '0; in[16*3 +: 16] = 16'h0300 + 16'(i - 1);
      step();
      vecs++; if (o_full !== (i >= 4)) begin errs++; $display("FAIL ovf_o_full i=%0d: got %b want %b", i, o_full, (i >= 4)); end
      vecs++; if (o_ready !== (i < 4)) begin errs++; $display("FAIL ovf_o_ready i=%0d: got %b want %b", i, o_ready, (i < 4)); end
      vecs++; if (overflow !== (i == 5)) begin errs++; $display("FAIL ovf_flag i=%0d: got %b want %b", i, overflow, (i == 5)); end
    end
    // Fill the other columns 4 deep, then drain; column 3 must give exactly 4 entries.
    for (int i = 0; i < 4; i++) begin
      wr = 8'hF7; in = rep(16'h0400 + 16'(i));
      step();
    end
    wr = '0; rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++; if (out[16*3 +: 16] !== 16'h0300 + 16'(i)) begin errs++; $display("FAIL ovf_col3 i=%0d: got %h want %h", i, out[16*3 +: 16], 16'h0300 + 16'(i)); end
      vecs++; if (out[0 +: 16] !== 16'h0400 + 16'(i)) begin errs++; $display("FAIL ovf_col0 i=%0d: got %h want %h", i, out[0 +: 16], 16'h0400 + 16'(i)); end
    end
    rd = 1'b0;
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL ovf_col3_cnt4: got o_valid %b want 0", o_valid); end
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_write_pop();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      wr = 8'hFF; in = rep(16'h5000 + 16'(r));
      step();
    end
    vecs++; if (o_full !== 1'b1) begin errs++; $display("FAIL fwp_setup_full: got %b want 1", o_full); end
    wr = 8'hFF; in = rep(16'hAAAA); rd = 1'b1;
    step();
    wr = '0;
    vecs++; if (out !== rep(16'h5000)) begin errs++; $display("FAIL fwp_first_out: got %h want %h", out, rep(16'h5000)); end
    vecs++; if (o_full !== 1'b1) begin errs++; $display("FAIL fwp_cnt_stays4: got o_full %b want 1", o_full); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fwp_overflow: got %b want 0", overflow); end
    for (int p = 1; p <= 4; p++) begin
      step();
      vecs++;
      if (out !== ((p == 4) ? rep(16'hAAAA) : rep(16'h5000 + 16'(p)))) begin
        errs++; $display("FAIL fwp_pop p=%0d: got %h want %h", p, out,
                         (p == 4) ? rep(16'hAAAA) : rep(16'h5000 + 16'(p)));
      end
    end
    rd = 1'b0;
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL fwp_drained: got %b want 0", o_valid); end
  endtask

  task automatic test_wrap_stream();
    do_reset();
    rd = 1'b1;
    for (int c = 0; c < 22; c++) begin
      wr = (c < 20) ? 8'hFF : 8'h00;
      in = rep(16'(c));
      step();
      if (c >= 1 && c <= 20) begin
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL wrap_valid c=%0d: got %b want 1", c, out_valid); end
        vecs++; if (out !== rep(16'(c - 1))) begin errs++; $display("FAIL wrap_out c=%0d: got %h want %h", c, out, rep(16'(c - 1))); end
      end
    end
    rd = 1'b0; wr = '0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL wrap_end_valid: got %b want 0", out_valid); end
    vecs++; if (o_full !== 1'b0) begin errs++; $display("FAIL wrap_never_full: got %b want 0", o_full); end
  endtask

  task automatic test_reset_mid_stream();
    logic [127:0] exp_row;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      wr = 8'hFF; in = rep(16'h1234);
      step();
    end
    // Two extra writes to column 0 push it past full to set overflow.
    for (int r = 0; r < 2; r++) begin
      wr = 8'h01; in = rep(16'hDEAD);
      step();
    end
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    vecs++; if (out !== rep(16'h1234)) begin errs++; $display("FAIL rms_pre_out: got %h want %h", out, rep(16'h1234)); end
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL rms_pre_ovf: got %b want 1", overflow); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL rms_o_valid: got %b want 0", o_valid); end
    vecs++; if (out !== 128'h0) begin errs++; $display("FAIL rms_out: got %h want 0", out); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL rms_overflow: got %b want 0", overflow); end
    vecs++; if (o_full !== 1'b0) begin errs++; $display("FAIL rms_o_full: got %b want 0", o_full); end
    wr = 8'hFF;
    for (int k = 0; k < 8; k++) in[16*k +: 16] = 16'h5678 + 16'(k);
    exp_row = in;
    step();
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    vecs++; if (out !== exp_row) begin errs++; $display("FAIL rms_new_out: got %h want %h", out, exp_row); end
    vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL rms_only_new: got %b want 0", o_valid); end
  endtask

  initial begin
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    test_reset();
    test_staggered_fill();
    test_idle_read();
    test_full_overflow();
    test_full_write_pop();
    test_wrap_stream();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/psum_align_fifo.md
# psum_align_fifo

Column-deskew output buffer between the systolic array and the SFP stage. The array's columns emit partial sums on staggered cycles with one write strobe per column. The block holds each column's psums in an independent FIFO and releases a complete row only when every column holds at least one entry. It presents the row to the SFP as a single `psum_bw*col` vector with a one-cycle valid pulse.

## Interface
- `col`, 8, number of array columns / FIFO lanes
- `psum_bw`, 16, psum width per column
- `depth`, 64, entries per column FIFO; power of two, ≥2
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  reset, synchronous, active-high
- `wr`  in  col  per-column write strobe; bit k pushes slice k of `in`
- `in`  in  psum_bw*col  column k data at `[psum_bw*(k+1)-1:psum_bw*k]`
- `rd`  in  1  pop request for one full row
- `out`  out  psum_bw*col  registered row data; feeds SFP `in`
- `out_valid`  out  1  one-cycle pulse, row on `out` is new; feeds SFP `valid_in`
- `o_valid`  out  1  every column non-empty (row available)
- `o_full`  out  1  any column FIFO full
- `o_ready`  out  1  `~o_full`
- `overflow`  out  1  sticky, a write was dropped

## Operation
- Per column k: count `cnt[k]` (clog2(depth)+1 bits), write pointer, read pointer (clog2(depth) bits, wrap modulo depth with no special case).
- `o_valid` = AND over k of (`cnt[k]` != 0). It is combinational from registered counts.
- `o_full` = OR over k of (`cnt[k]` == depth).
- Pop accepted = `rd & o_valid`. On accept, every column advances its read pointer and decrements its count.
- `rd` while `!o_valid` is ignored: no pointer or count change, no `out_valid`.
- Write to column k is accepted when `wr[k]` and (`cnt[k]` < depth or pop accepted this cycle).
- A write to a full column with no same-cycle pop is dropped. `overflow` is set and stays set until reset.
- Write and pop on the same column in the same cycle: the count is unchanged and both pointers advance.
- Writes to different columns are independent. Any subset of `wr` may be high.
- Data is stored unmodified. There is no arithmetic on psums.
- `out` updates only on an accepted pop and holds its value otherwise.

## Timing
- Reset: all counts and pointers are 0. `out`=0, `out_valid`=0, `overflow`=0, `o_valid`=0, `o_full`=0, `o_ready`=1. Storage contents are not cleared.
- Reset mid-operation discards all buffered data. The next cycle matches post-reset state.
- Write-to-visibility: `o_valid` rises the cycle after the edge that writes the last empty column.
- Pop latency: accepted pop at edge N puts head data on `out` with `out_valid`=1 after edge N.
- Throughput: one row per cycle with `rd` held high while `o_valid`.
- `o_valid` drops the cycle after the pop that empties any column, unless that column was written on the same edge.

## Structure
- Package `psum_align_pkg`: default `COL`, `PSUM_BW`, `DEPTH` constants; address-width and count-width derivation (clog2).
- Sub-module `col_fifo`: single-lane synchronous FIFO.
  - Ports: `clk`, `reset`, `push`, `pop`, `din`, `dout`, `cnt`.
  - `dout` is the combinational head. The parent registers it into `out`.
- Top level instantiates `col` `col_fifo`s via generate. It holds `o_valid`/`o_full` reduction, pop/accept logic, the `out`/`out_valid` registers and the sticky `overflow`.

## Test plan
- **Staggered fill.** col=8, depth=4. Assert `wr[k]` at cycle k with data 16'h0100+k.
  - `o_valid` rises only the cycle after k=7.
  - `rd` → next cycle `out` = {0x0107,…,0x0100}, `out_valid` pulse of 1 cycle.
- **Idle read.** `rd` held high with all FIFOs empty for 5 cycles → `out_valid`=0 throughout, `out` unchanged, counts stay 0.
- **Full and overflow.**
  - Write column 3 five times (depth=4) → `o_full`=1 after the 4th, `o_ready`=0.
  - The 5th write is dropped, `overflow`=1 and stays 1.
  - The column 3 count stays 4.
- **Full write with pop.**
  - Setup: all columns at count 4.
  - Stimulus: assert `rd` and `wr`=8'hFF with data 0xAAAA in the same cycle.
  - Required: counts stay 4, `overflow` stays 0. The 0xAAAA row appears on `out` on the 4th subsequent pop.
- **Wrap-around streaming.** Continuous full-row writes of an incrementing pattern (0…19) with `rd` held high, depth=4, 20 rows. `out` shows 0…19 in order with no gaps after the initial latency.
- **Reset mid-stream.**
  - Stimulus: assert `reset` for one cycle with 2 rows buffered and `out`=0x1234 pattern.
  - Required next cycle: `o_valid`=0, `out`=0, `overflow`=0.
  - A subsequent single-row fill returns only the new data.
